// File: rtl/nv_nvdla_cacc_delivery_ctrl_pkg.sv
// Shared definitions for the CACC delivery buffer controller and the delivery buffer.
// Holds the controller state encoding and the buffer geometry defaults.
package nv_nvdla_cacc_delivery_ctrl_pkg;

  localparam int DBUF_AWIDTH_DEF = 6;
  localparam int DBUF_WIDTH_DEF  = 512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } cacc_dlv_state_t;

endpackage

// File: rtl/nv_nvdla_cacc_dlv_ptr.sv
// Wrap-around circular-buffer pointer with an increment enable.
// Wraps naturally at 2^AWIDTH and only returns to zero on reset.
module nv_nvdla_cacc_dlv_ptr
  import nv_nvdla_cacc_delivery_ctrl_pkg::*;
#(
  parameter int AWIDTH = DBUF_AWIDTH_DEF
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rst,
  input  logic              inc,
  output logic [AWIDTH-1:0] ptr
);

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + AWIDTH'(1);
    end
  end

endmodule

// File: rtl/nv_nvdla_cacc_delivery_ctrl.sv
// Write/read controller for the CACC delivery buffer RAM: circular write of accepted
// lines, one read per stored line when the buffer is ready, and layer-end tracking.
module nv_nvdla_cacc_delivery_ctrl
  import nv_nvdla_cacc_delivery_ctrl_pkg::*;
#(
  parameter int DBUF_AWIDTH = DBUF_AWIDTH_DEF,
  parameter int DBUF_WIDTH  = DBUF_WIDTH_DEF
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rst,
  input  logic                   op_en,
  input  logic                   dlv_valid,
  output logic                   dlv_ready,
  input  logic [DBUF_WIDTH-1:0]  dlv_data,
  input  logic                   dlv_layer_end,
  output logic                   dbuf_wr_en,
  output logic [DBUF_AWIDTH-1:0] dbuf_wr_addr,
  output logic [DBUF_WIDTH-1:0]  dbuf_wr_data,
  input  logic                   dbuf_rd_ready,
  output logic                   dbuf_rd_en,
  output logic [DBUF_AWIDTH-1:0] dbuf_rd_addr,
  output logic                   dbuf_rd_layer_end,
  output logic                   busy,
  output logic                   layer_done
);

  localparam int DEPTH = 1 << DBUF_AWIDTH;
  localparam logic [DBUF_AWIDTH+1:0] DEPTH_LIM = (DBUF_AWIDTH+2)'(DEPTH);

  cacc_dlv_state_t        state;
  cacc_dlv_state_t        state_nxt;
  logic [DBUF_AWIDTH:0]   occ;
  logic [DBUF_AWIDTH:0]   occ_nxt;
  logic [DBUF_AWIDTH+1:0] occ_pend;
  logic [DBUF_AWIDTH-1:0] wr_ptr;
  logic [DBUF_AWIDTH-1:0] rd_ptr;
  logic [DBUF_AWIDTH-1:0] le_addr;
  logic                   le_vld;
  logic                   accept;
  logic                   rd_consume;
  logic                   layer_done_nxt;

  nv_nvdla_cacc_dlv_ptr #(.AWIDTH(DBUF_AWIDTH)) u_wr_ptr (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rst (nvdla_core_rst),
    .inc            (dbuf_wr_en),
    .ptr            (wr_ptr)
  );

  nv_nvdla_cacc_dlv_ptr #(.AWIDTH(DBUF_AWIDTH)) u_rd_ptr (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rst (nvdla_core_rst),
    .inc            (rd_consume),
    .ptr            (rd_ptr)
  );

  assign dbuf_wr_addr      = wr_ptr;
  assign dbuf_rd_addr      = rd_ptr;
  assign busy              = (state != IDLE);
  // The registered line still waiting to be written counts against free space.
  assign occ_pend          = {1'b0, occ} + (DBUF_AWIDTH+2)'(dbuf_wr_en);
  assign dbuf_rd_en        = (occ != '0) & dbuf_rd_ready & (state != IDLE);
  assign rd_consume        = dbuf_rd_en & dbuf_rd_ready;
  assign dbuf_rd_layer_end = rd_consume & le_vld & (rd_ptr == le_addr);
  assign accept            = dlv_valid & dlv_ready;

  always_comb begin
    occ_nxt = occ;
    case ({dbuf_wr_en, rd_consume})
      2'b10:   occ_nxt = occ + (DBUF_AWIDTH+1)'(1);
      2'b01:   occ_nxt = occ - (DBUF_AWIDTH+1)'(1);
      default: occ_nxt = occ;
    endcase
  end

  always_comb begin
    state_nxt      = state;
    dlv_ready      = 1'b0;
    layer_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (op_en) state_nxt = RUN;
      end
      RUN: begin
        dlv_ready = (occ_pend < DEPTH_LIM);
        if (dlv_valid && dlv_ready && dlv_layer_end) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (dbuf_rd_layer_end && (occ_nxt == '0)) begin
          state_nxt      = IDLE;
          layer_done_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state      <= IDLE;
      occ        <= '0;
      layer_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      occ        <= occ_nxt;
      layer_done <= layer_done_nxt;
    end
  end

  // The layer-end line lands one slot further if a write is already in flight.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      le_vld  <= 1'b0;
      le_addr <= '0;
    end else if (accept && dlv_layer_end) begin
      le_vld  <= 1'b1;
      le_addr <= wr_ptr + DBUF_AWIDTH'(dbuf_wr_en);
    end else if (dbuf_rd_layer_end) begin
      le_vld  <= 1'b0;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      dbuf_wr_en   <= 1'b0;
      dbuf_wr_data <= '0;
    end else begin
      dbuf_wr_en <= accept;
      if (accept) dbuf_wr_data <= dlv_data;
    end
  end

endmodule

// File: tb/tb_nv_nvdla_cacc_delivery_ctrl.sv
// Self-checking bench for nv_nvdla_cacc_delivery_ctrl (DEPTH=16): vector table,
// directed corner sequences and randomized layers against a counter-based model.
module tb_nv_nvdla_cacc_delivery_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 64;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          op_en = 1'b0;
  logic          dlv_valid = 1'b0;
  logic          dlv_ready;
  logic [DW-1:0] dlv_data = '0;
  logic          dlv_layer_end = 1'b0;
  logic          dbuf_wr_en;
  logic [AW-1:0] dbuf_wr_addr;
  logic [DW-1:0] dbuf_wr_data;
  logic          dbuf_rd_ready = 1'b0;
  logic          dbuf_rd_en;
  logic [AW-1:0] dbuf_rd_addr;
  logic          dbuf_rd_layer_end;
  logic          busy;
  logic          layer_done;

  int tests = 0;
  int fails = 0;

  nv_nvdla_cacc_delivery_ctrl #(.DBUF_AWIDTH(AW), .DBUF_WIDTH(DW)) dut (
    .nvdla_core_clk    (clk),
    .nvdla_core_rst    (rst),
    .op_en             (op_en),
    .dlv_valid         (dlv_valid),
    .dlv_ready         (dlv_ready),
    .dlv_data          (dlv_data),
    .dlv_layer_end     (dlv_layer_end),
    .dbuf_wr_en        (dbuf_wr_en),
    .dbuf_wr_addr      (dbuf_wr_addr),
    .dbuf_wr_data      (dbuf_wr_data),
    .dbuf_rd_ready     (dbuf_rd_ready),
    .dbuf_rd_en        (dbuf_rd_en),
    .dbuf_rd_addr      (dbuf_rd_addr),
    .dbuf_rd_layer_end (dbuf_rd_layer_end),
    .busy              (busy),
    .layer_done        (layer_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: lines are counted in/out since reset; addresses follow from the
  // counts modulo DEPTH, and each stored slot remembers whether it closed a layer.
  int       wr_cnt, rd_cnt;
  bit       pend, pend_le;
  logic [DW-1:0] pend_data;
  bit       mem_le [DEPTH];
  bit       busy_m, le_seen_m, done_m, armed;

  int rd_seen, ovl_cnt, done_cnt;
  int le_addrs[$];

  always @(negedge clk) begin
    int  occ_m, ra, wa;
    bit  ready_e, rd_e, le_e, op_start;
    occ_m = wr_cnt - rd_cnt;
    ra = rd_cnt % DEPTH;
    wa = wr_cnt % DEPTH;
    ready_e = busy_m && !le_seen_m && ((occ_m + int'(pend)) < DEPTH);
    rd_e    = busy_m && (occ_m != 0) && (dbuf_rd_ready == 1'b1);
    le_e    = rd_e && mem_le[ra];
    if (armed) begin
      checkOutput("mdl_dlv_ready", dlv_ready, ready_e);
      checkOutput("mdl_wr_en", dbuf_wr_en, pend);
      if (pend) begin
        checkOutput("mdl_wr_addr", dbuf_wr_addr, wa);
        checkOutput("mdl_wr_data", dbuf_wr_data, pend_data);
      end
      checkOutput("mdl_rd_en", dbuf_rd_en, rd_e);
      if (rd_e) checkOutput("mdl_rd_addr", dbuf_rd_addr, ra);
      checkOutput("mdl_rd_layer_end", dbuf_rd_layer_end, le_e);
      checkOutput("mdl_busy", busy, busy_m);
      checkOutput("mdl_layer_done", layer_done, done_m);
      if (dbuf_rd_en && dbuf_rd_ready) rd_seen++;
      if (dbuf_wr_en && dbuf_rd_en) ovl_cnt++;
      if (layer_done) done_cnt++;
      if (dbuf_rd_layer_end) le_addrs.push_back(int'(dbuf_rd_addr));
    end
    if (rst) begin
      wr_cnt = 0; rd_cnt = 0; pend = 0; pend_le = 0; pend_data = '0;
      busy_m = 0; le_seen_m = 0; done_m = 0; armed = 1;
      for (int i = 0; i < DEPTH; i++) mem_le[i] = 0;
    end else if (armed) begin
      op_start = op_en && !busy_m;
      done_m = 0;
      if (rd_e) begin
        rd_cnt++;
        if (le_e) begin
          done_m = 1; busy_m = 0; le_seen_m = 0;
        end
      end
      if (pend) begin
        mem_le[wa] = pend_le;
        wr_cnt++;
      end
      if (op_start) busy_m = 1;
      pend      = ready_e && dlv_valid;
      pend_data = dlv_data;
      pend_le   = dlv_layer_end;
      if (pend && pend_le) le_seen_m = 1;
    end
  end

  bit rand_rd = 0;
  always @(posedge clk) begin
    if (rand_rd) begin
      #1;
      dbuf_rd_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic          op_en, valid, le, rd_ready;
    logic [DW-1:0] data;
    logic          ready, wr_en;
    logic [AW-1:0] wr_addr;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_le, busy, done;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1; op_en = 0; dlv_valid = 0; dlv_layer_end = 0; dbuf_rd_ready = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    op_en = v.op_en; dlv_valid = v.valid; dlv_layer_end = v.le;
    dbuf_rd_ready = v.rd_ready; dlv_data = v.data;
    @(negedge clk);
    checkOutput($sformatf("vec%0d_ready", idx), dlv_ready, v.ready);
    checkOutput($sformatf("vec%0d_wr_en", idx), dbuf_wr_en, v.wr_en);
    checkOutput($sformatf("vec%0d_wr_addr", idx), dbuf_wr_addr, v.wr_addr);
    checkOutput($sformatf("vec%0d_rd_en", idx), dbuf_rd_en, v.rd_en);
    checkOutput($sformatf("vec%0d_rd_addr", idx), dbuf_rd_addr, v.rd_addr);
    checkOutput($sformatf("vec%0d_rd_le", idx), dbuf_rd_layer_end, v.rd_le);
    checkOutput($sformatf("vec%0d_busy", idx), busy, v.busy);
    checkOutput($sformatf("vec%0d_done", idx), layer_done, v.done);
    tick();
  endtask

  task automatic start_layer();
    op_en = 1'b1;
    tick();
    op_en = 1'b0;
  endtask

  task automatic send_line(input logic [DW-1:0] d, input logic le, input bit noise);
    bit ok = 0;
    dlv_valid = 1'b1; dlv_data = d; dlv_layer_end = le;
    for (int k = 0; k < 200; k++) begin
      if (noise) op_en = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (dlv_ready) begin
        ok = 1;
        break;
      end
      tick();
    end
    tick();
    dlv_valid = 1'b0; dlv_layer_end = 1'b0; op_en = 1'b0;
    checkOutput("line_accepted", ok, 1);
  endtask

  task automatic wait_done(input int bound);
    bit ok = 0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (layer_done) begin
        ok = 1;
        break;
      end
      tick();
    end
    tick();
    checkOutput("layer_done_seen", ok, 1);
  endtask

  initial begin
    logic [DW-1:0] a5;
    int acc;
    a5 = {8{8'hA5}};

    // Single-line layer, then dlv_valid while IDLE and op_en while RUN.
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, a5, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b0, 4'd1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b0, 4'd1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, a5, 1'b0, 1'b0, 4'd1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1, a5, 1'b0, 1'b0, 4'd1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, '0, 1'b1, 1'b0, 4'd1, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1, '0, 1'b1, 1'b0, 4'd1, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b1, 1'b0, 4'd1, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0});

    tick();
    doReset();
    @(negedge clk);
    checkOutput("rst_ready", dlv_ready, 0);
    checkOutput("rst_wr_en", dbuf_wr_en, 0);
    checkOutput("rst_wr_data", dbuf_wr_data, 0);
    checkOutput("rst_busy", busy, 0);
    tick();
    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

    // Fill to full with reads blocked, then drain in order and finish the layer.
    doReset();
    start_layer();
    acc = 0;
    dlv_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      dlv_data = DW'(64'h1000 + acc);
      @(negedge clk);
      if (dlv_ready) acc++;
      tick();
    end
    dlv_valid = 1'b0;
    @(negedge clk);
    checkOutput("full_accept_count", acc, 16);
    checkOutput("full_ready_low", dlv_ready, 0);
    checkOutput("full_no_read", dbuf_rd_en, 0);
    tick();
    rd_seen = 0;
    dbuf_rd_ready = 1'b1;
    @(negedge clk);
    checkOutput("full_first_rd_en", dbuf_rd_en, 1);
    checkOutput("full_first_rd_addr", dbuf_rd_addr, 0);
    tick();
    for (int i = 16; i < 20; i++) send_line(DW'(64'h1000 + i), (i == 19), 0);
    wait_done(100);
    checkOutput("full_total_reads", rd_seen, 20);

    // Three 7-line layers wrap the 16-entry buffer.
    doReset();
    le_addrs.delete();
    rand_rd = 1;
    for (int l = 0; l < 3; l++) begin
      start_layer();
      for (int i = 0; i < 7; i++) send_line({$urandom, $urandom}, (i == 6), 0);
      wait_done(500);
    end
    rand_rd = 0;
    checkOutput("wrap_le_count", le_addrs.size(), 3);
    if (le_addrs.size() == 3) begin
      checkOutput("wrap_le_addr0", le_addrs[0], 6);
      checkOutput("wrap_le_addr1", le_addrs[1], 13);
      checkOutput("wrap_le_addr2", le_addrs[2], 4);
    end

    // Streaming at occupancy 1: each cycle writes one line while reading the previous.
    doReset();
    dbuf_rd_ready = 1'b1;
    ovl_cnt = 0;
    rd_seen = 0;
    start_layer();
    for (int i = 0; i < 10; i++) send_line(DW'(64'h2000 + i), (i == 9), 0);
    wait_done(50);
    checkOutput("stream_overlap", ovl_cnt, 9);
    checkOutput("stream_reads", rd_seen, 10);

    // Reset in DRAIN with five lines held.
    doReset();
    start_layer();
    for (int i = 0; i < 5; i++) send_line(DW'(64'h3000 + i), (i == 4), 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dbuf_rd_ready = 1'b1;
    done_cnt = 0;
    @(negedge clk);
    checkOutput("midrst_ready", dlv_ready, 0);
    checkOutput("midrst_wr_en", dbuf_wr_en, 0);
    checkOutput("midrst_wr_addr", dbuf_wr_addr, 0);
    checkOutput("midrst_wr_data", dbuf_wr_data, 0);
    checkOutput("midrst_rd_en", dbuf_rd_en, 0);
    checkOutput("midrst_rd_addr", dbuf_rd_addr, 0);
    checkOutput("midrst_rd_le", dbuf_rd_layer_end, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", layer_done, 0);
    tick();
    for (int i = 0; i < 4; i++) tick();
    checkOutput("midrst_no_done", done_cnt, 0);
    start_layer();
    send_line(DW'(64'h4000), 1'b1, 0);
    @(negedge clk);
    checkOutput("midrst_new_wr_en", dbuf_wr_en, 1);
    checkOutput("midrst_new_wr_addr", dbuf_wr_addr, 0);
    tick();
    wait_done(20);

    // Randomized layers with random gaps, read backpressure and op_en noise.
    doReset();
    rand_rd = 1;
    for (int l = 0; l < 6; l++) begin
      int n;
      n = $urandom_range(1, 40);
      start_layer();
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) tick();
        send_line({$urandom, $urandom}, (i == n - 1), 1);
      end
      wait_done(3000);
      if ($urandom_range(0, 1) == 1) tick();
    end
    rand_rd = 0;
    dbuf_rd_ready = 1'b0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
